// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - MIPS ID decode into ALU op code and ID/EX register; optional LOAD_USE_STALL_EN load-use stall
module alu_issue_stage #(
  parameter logic [4:0] RA_ADDR = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [4:0]  ex_alu_code,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic        ex_alusrc_b,
  output logic        ex_shift_a,
  output logic        ex_wr_en,
  output logic [4:0]  ex_wr_addr,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);

  localparam logic [4:0] ALU_ADD  = 5'b00000, ALU_AND  = 5'b00001, ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011, ALU_NOR  = 5'b00100, ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_ANDI = 5'b00110, ALU_XORI = 5'b00111, ALU_ORI  = 5'b01000;
  localparam logic [4:0] ALU_JR   = 5'b01001, ALU_BEQ  = 5'b01010, ALU_BNE  = 5'b01011;
  localparam logic [4:0] ALU_BGEZ = 5'b01100, ALU_BGTZ = 5'b01101, ALU_BLEZ = 5'b01110;
  localparam logic [4:0] ALU_BLTZ = 5'b01111, ALU_SLL  = 5'b10000, ALU_SRL  = 5'b10001;
  localparam logic [4:0] ALU_SRA  = 5'b10010, ALU_SLT  = 5'b10011, ALU_SLTU = 5'b10100;

  typedef struct packed {
    logic [4:0]  alu_code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        alusrc_b;
    logic        shift_a;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } entry_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs_f;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [15:0] imm16;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign op       = id_instr[31:26];
  assign rs_f     = id_instr[25:21];
  assign rt_f     = id_instr[20:16];
  assign rd_f     = id_instr[15:11];
  assign funct    = id_instr[5:0];
  assign imm16    = id_instr[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  entry_t dec;
  entry_t entry_d, entry_q;
  logic   valid_d, valid_q;
  logic   stall;
  logic   transfer;

  // Decode the ID instruction into the fields the EX stage consumes
  always_comb begin
    dec          = '0;
    dec.alu_code = ALU_ADD;
    dec.rs       = rs_f;
    dec.rt       = rt_f;
    dec.imm      = imm_sext;
    dec.shamt    = id_instr[10:6];
    dec.wr_addr  = rt_f;
    unique case (op)
      6'b000000: begin
        dec.wr_addr = rd_f;
        dec.wr_en   = 1'b1;
        case (funct)
          6'b100000, 6'b100001: dec.alu_code = ALU_ADD;
          6'b100010, 6'b100011: dec.alu_code = ALU_SUB;
          6'b100100: dec.alu_code = ALU_AND;
          6'b100101: dec.alu_code = ALU_OR;
          6'b100110: dec.alu_code = ALU_XOR;
          6'b100111: dec.alu_code = ALU_NOR;
          6'b101010: dec.alu_code = ALU_SLT;
          6'b101011: dec.alu_code = ALU_SLTU;
          6'b000000: begin dec.alu_code = ALU_SLL; dec.shift_a = 1'b1; end
          6'b000010: begin dec.alu_code = ALU_SRL; dec.shift_a = 1'b1; end
          6'b000011: begin dec.alu_code = ALU_SRA; dec.shift_a = 1'b1; end
          6'b001000: begin dec.alu_code = ALU_JR;  dec.wr_en   = 1'b0; end
          default:   begin dec.illegal  = 1'b1;    dec.wr_en   = 1'b0; end
        endcase
      end
      6'b001000, 6'b001001: begin dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b001010: begin dec.alu_code = ALU_SLT;  dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b001011: begin dec.alu_code = ALU_SLTU; dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b100011: begin dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; dec.mem_read = 1'b1; end
      6'b101011: begin dec.alusrc_b = 1'b1; dec.mem_write = 1'b1; end
      6'b001100: begin dec.alu_code = ALU_ANDI; dec.imm = imm_zext; dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b001110: begin dec.alu_code = ALU_XORI; dec.imm = imm_zext; dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b001101: begin dec.alu_code = ALU_ORI;  dec.imm = imm_zext; dec.alusrc_b = 1'b1; dec.wr_en = 1'b1; end
      6'b001111: begin
        dec.imm      = {imm16, 16'h0000};
        dec.rs       = 5'd0;
        dec.alusrc_b = 1'b1;
        dec.wr_en    = 1'b1;
      end
      6'b000100: dec.alu_code = ALU_BEQ;
      6'b000101: dec.alu_code = ALU_BNE;
      6'b000110: dec.alu_code = ALU_BLEZ;
      6'b000111: dec.alu_code = ALU_BGTZ;
      6'b000001: begin
        if (rt_f == 5'b00001)      dec.alu_code = ALU_BGEZ;
        else if (rt_f == 5'b00000) dec.alu_code = ALU_BLTZ;
        else                       dec.illegal  = 1'b1;
      end
      6'b000010: dec.alu_code = ALU_ADD;
      6'b000011: begin dec.wr_en = 1'b1; dec.wr_addr = RA_ADDR; end
      default:   dec.illegal = 1'b1;
    endcase
  end

`ifdef LOAD_USE_STALL_EN
  logic uses_rt;
  // Hold the dependent instruction in ID while a load it reads sits in EX
  always_comb begin
    uses_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
              (op == 6'b000110) || (op == 6'b000111) || (op == 6'b101011);
    stall   = valid_q && entry_q.mem_read && (entry_q.wr_addr != 5'd0) &&
              ((rs_f == entry_q.wr_addr) || (uses_rt && (rt_f == entry_q.wr_addr)));
  end
`else
  assign stall = 1'b0;
`endif

  assign id_ready = ~flush & ~stall & (~valid_q | ex_ready);
  assign transfer = id_valid & id_ready;

  // Next state of the ID/EX register: flush, then load, then drain, else hold
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (transfer) begin
      valid_d = 1'b1;
      entry_d = dec;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_code  = entry_q.alu_code;
  assign ex_rs        = entry_q.rs;
  assign ex_rt        = entry_q.rt;
  assign ex_imm       = entry_q.imm;
  assign ex_shamt     = entry_q.shamt;
  assign ex_alusrc_b  = entry_q.alusrc_b;
  assign ex_shift_a   = entry_q.shift_a;
  assign ex_wr_addr   = entry_q.wr_addr;
  assign ex_wr_en     = valid_q & entry_q.wr_en;
  assign ex_mem_read  = valid_q & entry_q.mem_read;
  assign ex_mem_write = valid_q & entry_q.mem_write;
  assign ex_illegal   = valid_q & entry_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Produces the 5-bit ALU operation code that the ALU consumes, plus operand-select and writeback controls.
- Decodes a 32-bit MIPS instruction in ID and registers the result into the ID/EX pipeline register.
- Uses a valid/ready handshake on both sides and supports flush (branch/jump redirect).
- Sits between instruction fetch/ID and the EX-stage ALU.

Parameters:
- RA_ADDR, 31, destination register written by jal.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  id_instr holds a valid instruction
id_ready  output  1  stage accepts id_instr this cycle
id_instr  input  32  instruction word
flush  input  1  squash EX-bound contents and incoming instruction
ex_ready  input  1  EX consumes the registered entry this cycle
ex_valid  output  1  registered entry is valid
ex_alu_code  output  5  ALU operation select
ex_rs  output  5  source register A index
ex_rt  output  5  source register B index
ex_imm  output  32  extended immediate
ex_shamt  output  5  shift amount
ex_alusrc_b  output  1  1: B operand = ex_imm
ex_shift_a  output  1  1: A operand = zero-extended ex_shamt
ex_wr_en  output  1  register writeback enable
ex_wr_addr  output  5  writeback register index
ex_mem_read  output  1  load
ex_mem_write  output  1  store
ex_illegal  output  1  unrecognised opcode/funct

Behaviour:
- Reset: all ex_* outputs 0; ex_valid=0.
- Handshake:
  - id_ready = ~flush & ~stall & (~ex_valid | ex_ready); stall is 0 unless the optional feature is enabled.
  - A transfer occurs when id_valid & id_ready. The next edge loads decoded fields and sets ex_valid=1. Latency is 1 cycle.
  - Else if ex_ready: ex_valid<=0.
  - Else: hold all registers.
- Flush: next edge ex_valid<=0. Incoming instruction is not accepted (id_ready=0). Flush dominates all other events.
- Whenever ex_valid=0: ex_wr_en, ex_mem_read, ex_mem_write and ex_illegal read 0. Data fields are don't-care but hold.
- ALU codes: add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101, andi 00110, xori 00111, ori 01000, jr 01001, beq 01010, bne 01011, bgez 01100, bgtz 01101, blez 01110, bltz 01111, sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100.
- R-type (op 000000), funct mapping: 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 101011 sltu; 000000 sll; 000010 srl; 000011 sra; 001000 jr.
  - R-type wr_addr = rd. wr_en=1 except jr.
  - Shifts set ex_shift_a=1.
  - sll with instr==0 (nop) decodes as sll, wr_addr 0.
- I-type, ex_imm extension:
  - Sign-extended: addi/addiu (001000/001001) add; slti 001010 slt; sltiu 001011 sltu; lw 100011 add; sw 101011 add.
  - Zero-extended: andi 001100; xori 001110; ori 001101.
  - lui 001111 → add with ex_imm={imm,16'h0}; ex_rs forced 0.
  - I-type alusrc_b=1; wr_addr=rt; wr_en=1 except sw and branches.
- Branches (alusrc_b=0):
  - beq 000100, bne 000101, blez 000110, bgtz 000111.
  - REGIMM 000001: rt=00001 bgez, rt=00000 bltz, other rt illegal.
  - ex_imm = sign-extended offset.
- Jumps: j 000010 and jal 000011 decode as add, alusrc_b=0. jal sets wr_en=1, wr_addr=RA_ADDR.
- Any other op/funct: ex_illegal=1, alu_code add, wr_en/mem_read/mem_write=0.

Optional Feature:
- Macro LOAD_USE_STALL_EN.
- When defined: stall=1 when ex_valid & ex_mem_read & ex_wr_addr!=0 and the ID instruction reads ex_wr_addr (rs, or rt for R-type/branch/sw).
  - id_ready=0 while stalled.
  - If ex_ready, the load drains (ex_valid<=0, bubble). The dependent instruction transfers the next cycle.
- When undefined: stall tied 0; forwarding/hazard handling is external.

Test Plan:
1. Reset low mid-transfer with ex_valid=1 → ex_valid=0, all ex_* =0 immediately; id_ready=1 after release.
2. id_instr=0x2008FFFF (addi $8,$0,-1), ex_ready=1 → next cycle ex_alu_code=00000, ex_imm=0xFFFFFFFF, alusrc_b=1, wr_addr=8, wr_en=1.
3. id_instr=0x00094083 (sra $8,$9,2) then 0x3508FF00 (ori) back-to-back → codes 10010 (shift_a=1, shamt=2) then 01000 with imm=0x0000FF00.
4. ex_ready=0 with ex_valid=1 and new id_valid → id_ready=0, outputs hold; ex_ready=1 next → new entry loaded.
5. flush=1 together with id_valid=1 → ex_valid=0 next cycle, instruction not accepted, id_ready=0 that cycle.
6. With LOAD_USE_STALL_EN, lw $8 followed by add $9,$8,$8 → one bubble cycle (ex_valid=0), then the add is issued; opcode 0x3F → ex_illegal=1.
